// File: rtl/btn_conditioner.sv
// Per-channel push-button conditioner: 2-flop synchroniser, debounce FSM,
// registered active-low level plus press/release/long-press pulses.
module btn_conditioner #(
  parameter int N_BTN    = 3,
  parameter int DEB_CNT  = 1_999_999,
  parameter int LONG_CNT = 99_999_999,
  parameter int CNT_W    = 27
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic [N_BTN-1:0] i_Btn,
  output logic [N_BTN-1:0] o_Btn,
  output logic [N_BTN-1:0] o_fPress,
  output logic [N_BTN-1:0] o_fRelease,
  output logic [N_BTN-1:0] o_fLong
);

  typedef enum logic [1:0] {REL, PWAIT, PRS, RWAIT} state_t;

  localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEB_CNT);
  localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(LONG_CNT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           r_State [N_BTN];
  logic [CNT_W-1:0] r_Deb   [N_BTN];
  logic [CNT_W-1:0] r_Long  [N_BTN];
  logic [N_BTN-1:0] r_LongDone;
  logic [N_BTN-1:0] r_Sync1;
  logic [N_BTN-1:0] r_Sync;
  logic [N_BTN-1:0] r_Btn;
  logic [N_BTN-1:0] r_fPress;
  logic [N_BTN-1:0] r_fRelease;
  logic [N_BTN-1:0] r_fLong;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst) begin
      r_Sync1    <= '1;
      r_Sync     <= '1;
      r_Btn      <= '1;
      r_fPress   <= '0;
      r_fRelease <= '0;
      r_fLong    <= '0;
      r_LongDone <= '0;
      for (int k = 0; k < N_BTN; k++) begin
        r_State[k] <= REL;
        r_Deb[k]   <= '0;
        r_Long[k]  <= '0;
      end
    end else begin
      r_Sync1    <= i_Btn;
      r_Sync     <= r_Sync1;
      r_fPress   <= '0;
      r_fRelease <= '0;
      r_fLong    <= '0;
      for (int k = 0; k < N_BTN; k++) begin
        case (r_State[k])
          REL: begin
            if (!r_Sync[k]) begin
              r_State[k] <= PWAIT;
              r_Deb[k]   <= '0;
            end
          end
          PWAIT: begin
            if (r_Sync[k]) begin
              r_State[k] <= REL;
              r_Deb[k]   <= '0;
            end else if (r_Deb[k] == DEB_MAX) begin
              r_State[k]    <= PRS;
              r_Btn[k]      <= 1'b0;
              r_fPress[k]   <= 1'b1;
              r_Long[k]     <= '0;
              r_LongDone[k] <= 1'b0;
            end else begin
              r_Deb[k] <= r_Deb[k] + CNT_ONE;
            end
          end
          PRS: begin
            // Long counter saturates; long-done limits o_fLong to once per press
            if (r_Sync[k]) begin
              r_State[k] <= RWAIT;
              r_Deb[k]   <= '0;
            end else if (r_Long[k] < LONG_MAX) begin
              r_Long[k] <= r_Long[k] + CNT_ONE;
            end else if (!r_LongDone[k]) begin
              r_fLong[k]    <= 1'b1;
              r_LongDone[k] <= 1'b1;
            end
          end
          RWAIT: begin
            // A release bounce returns to PRS with the long-press progress kept
            if (!r_Sync[k]) begin
              r_State[k] <= PRS;
              r_Deb[k]   <= '0;
            end else if (r_Deb[k] == DEB_MAX) begin
              r_State[k]    <= REL;
              r_Btn[k]      <= 1'b1;
              r_fRelease[k] <= 1'b1;
            end else begin
              r_Deb[k] <= r_Deb[k] + CNT_ONE;
            end
          end
          default: begin
            r_State[k] <= REL;
            r_Deb[k]   <= '0;
          end
        endcase
      end
    end
  end

  assign o_Btn      = r_Btn;
  assign o_fPress   = r_fPress;
  assign o_fRelease = r_fRelease;
  assign o_fLong    = r_fLong;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with DEB_CNT=4, LONG_CNT=20, N_BTN=3.
module tb_btn_conditioner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] btn;
  logic [2:0] o_btn, o_press, o_rel, o_long;
  int         n_assert = 0;
  int         n_fail   = 0;

  btn_conditioner #(
    .N_BTN(3), .DEB_CNT(4), .LONG_CNT(20), .CNT_W(8)
  ) dut (
    .i_Clk(clk), .i_Rst(rst_n), .i_Btn(btn),
    .o_Btn(o_btn), .o_fPress(o_press), .o_fRelease(o_rel), .o_fLong(o_long)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Advance n edges; after each, o_Btn must equal exp_btn and no pulse may fire.
  task automatic run_quiet(input int n, input logic [2:0] exp_btn, input string tag);
    for (int i = 0; i < n; i++) begin
      tick();
      chk({tag, " level"}, {6'b0, o_btn}, {6'b0, exp_btn});
      chk({tag, " pulses"}, {o_press, o_rel, o_long}, 9'b0);
    end
  endtask

  // After an edge: check level and the three pulse vectors together.
  task automatic chk_all(input string tag, input logic [2:0] eb, input logic [2:0] ep,
                         input logic [2:0] er, input logic [2:0] el);
    chk({tag, " level"}, {6'b0, o_btn}, {6'b0, eb});
    chk({tag, " pulses"}, {o_press, o_rel, o_long}, {ep, er, el});
  endtask

  initial begin
    rst_n = 1'b0;
    btn   = 3'b000;
    #1;
    // Reset with all buttons pressed: outputs held released
    run_quiet(3, 3'b111, "reset");
    btn = 3'b111;
    run_quiet(1, 3'b111, "reset_idle");
    rst_n = 1'b1;
    run_quiet(4, 3'b111, "idle");

    // Clean press on channel 0
    btn = 3'b110;
    run_quiet(7, 3'b111, "press0_wait");
    tick();
    chk_all("press0_edge", 3'b110, 3'b001, 3'b000, 3'b000);
    tick();
    chk_all("press0_after", 3'b110, 3'b000, 3'b000, 3'b000);

    // Release bounce on channel 0: two high clocks then low again
    btn = 3'b111;
    run_quiet(2, 3'b110, "rbounce_hi");
    btn = 3'b110;
    run_quiet(8, 3'b110, "rbounce_lo");

    // Release channel 0 before the long threshold: release pulse, no long pulse
    btn = 3'b111;
    run_quiet(7, 3'b110, "rel0_wait");
    tick();
    chk_all("rel0_edge", 3'b111, 3'b000, 3'b001, 3'b000);
    run_quiet(2, 3'b111, "rel0_after");

    // Bounce rejection on channel 1: low 3 / high 2, four times
    for (int r = 0; r < 4; r++) begin
      btn = 3'b101;
      run_quiet(3, 3'b111, "bounce1_lo");
      btn = 3'b111;
      run_quiet(2, 3'b111, "bounce1_hi");
    end
    run_quiet(8, 3'b111, "bounce1_tail");

    // Long press on channel 2: 40 clocks low
    btn = 3'b011;
    run_quiet(7, 3'b111, "long2_wait");
    tick();
    chk_all("long2_press", 3'b011, 3'b100, 3'b000, 3'b000);
    run_quiet(20, 3'b011, "long2_hold");
    tick();
    chk_all("long2_pulse", 3'b011, 3'b000, 3'b000, 3'b100);
    run_quiet(11, 3'b011, "long2_nosecond");
    btn = 3'b111;
    run_quiet(7, 3'b011, "long2_relwait");
    tick();
    chk_all("long2_release", 3'b111, 3'b000, 3'b100, 3'b000);
    run_quiet(2, 3'b111, "long2_after");

    // Reset mid-press on channel 0
    btn = 3'b110;
    run_quiet(7, 3'b111, "rpress_wait");
    tick();
    chk_all("rpress_edge", 3'b110, 3'b001, 3'b000, 3'b000);
    tick();
    chk_all("rpress_after", 3'b110, 3'b000, 3'b000, 3'b000);
    rst_n = 1'b0;
    tick();
    chk_all("midreset", 3'b111, 3'b000, 3'b000, 3'b000);
    rst_n = 1'b1;
    run_quiet(7, 3'b111, "repress_wait");
    tick();
    chk_all("repress_edge", 3'b110, 3'b001, 3'b000, 3'b000);
    tick();
    chk_all("repress_after", 3'b110, 3'b000, 3'b000, 3'b000);

    // Simultaneous press on channels 1 and 2 while channel 0 stays held
    btn = 3'b000;
    run_quiet(7, 3'b110, "dual_wait");
    tick();
    chk_all("dual_edge", 3'b000, 3'b110, 3'b000, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Per-channel push-button conditioner, upstream of the stopwatch controller.
- Takes raw, bouncing, active-low board buttons (start, stop, record, ...).
- Per channel: 2-flop synchronisation, debounce state machine, and registered outputs:
  - clean active-low level, which the stopwatch edge-detects itself;
  - single-cycle press, release and long-press pulses for other consumers.
- N independent identical channels, one shared clock domain.

Parameters:
- N_BTN, 3, number of button channels.
- DEB_CNT, 1_999_999, debounce qualification length minus 1, in clocks (20 ms at 100 MHz).
- LONG_CNT, 99_999_999, long-press threshold in clocks after the press is qualified (1 s at 100 MHz).
- CNT_W, 27, width of each per-channel counter; must hold max(DEB_CNT, LONG_CNT).

Ports:
- i_Clk  in  1  system clock.
- i_Rst  in  1  reset; synchronous, active-low.
- i_Btn  in  N_BTN  raw buttons; active-low (0 = pressed); asynchronous, bouncing.
- o_Btn  out  N_BTN  debounced level; active-low; registered.
- o_fPress  out  N_BTN  1-cycle pulse per qualified press.
- o_fRelease  out  N_BTN  1-cycle pulse per qualified release.
- o_fLong  out  N_BTN  1-cycle pulse, at most once per press, when held LONG_CNT clocks.

Behaviour:
- Reset is synchronous, active-low, sampled only on the rising edge of i_Clk. While i_Rst = 0, on each edge:
  - sync flops <= all 1;
  - every channel state <= REL;
  - deb/long counters <= 0; long-done flag <= 0;
  - o_Btn <= all 1; o_fPress, o_fRelease, o_fLong <= all 0.
- Synchroniser: s1 <= i_Btn[k]; s <= s1. The state machine uses only s.
- Channel states: REL, PWAIT, PRS, RWAIT. One deb counter and one long counter per channel.
- REL:
  - s = 0 -> PWAIT, deb <= 0.
- PWAIT:
  - s = 1 -> REL, deb <= 0 (bounce, no pulse).
  - else deb = DEB_CNT -> PRS; o_Btn[k] <= 0; o_fPress[k] <= 1; long <= 0; long-done <= 0.
  - else deb <= deb + 1.
- PRS:
  - s = 1 -> RWAIT, deb <= 0.
  - else if long < LONG_CNT -> long <= long + 1.
  - else if long-done = 0 -> o_fLong[k] <= 1, long-done <= 1.
  - long saturates at LONG_CNT.
- RWAIT:
  - s = 0 -> PRS; deb <= 0; long counter and long-done held (no new press, no clear).
  - else deb = DEB_CNT -> REL; o_Btn[k] <= 1; o_fRelease[k] <= 1.
  - else deb <= deb + 1. Long counter frozen in RWAIT.
- Pulses: all pulse outputs default to 0 every cycle; high only for the single cycle following the qualifying edge.
- Latency:
  - Raw input stable low from edge k -> o_Btn low and o_fPress high after edge k + DEB_CNT + 3.
  - Release latency is the same.
  - o_fLong rises LONG_CNT + 1 cycles after o_fPress rises, if held continuously.
- Glitch rejection: a low (or high) run of up to DEB_CNT + 1 synchronised cycles produces no output change.
- Channels are fully independent. Simultaneous presses on several channels yield simultaneous pulses.
- A press released before the long threshold gives o_fRelease with no o_fLong.
- Reset mid-press: outputs return to released on the next edge. If the button is still held when reset deasserts, a fresh press is qualified after the full debounce delay, with a new o_fPress.
- No combinational path from i_Btn to any output.

Test Plan:
All scenarios use DEB_CNT = 4, LONG_CNT = 20, N_BTN = 3.
- Reset: hold i_Rst = 0 for 3 clocks with i_Btn = 3'b000 -> o_Btn = 3'b111 and all pulses 0 throughout.
- Clean press:
  - Stimulus: i_Btn[0] low from edge k, held.
  - o_Btn[0] = 0 and o_fPress[0] = 1 after edge k + 7; o_fPress[0] = 0 one cycle later.
  - Other channels unchanged.
- Bounce rejection:
  - Stimulus: i_Btn[1] toggles low 3 clocks / high 2 clocks, four times, then stays high.
  - Required: o_Btn[1] stays 1; no pulses on any channel.
- Long press:
  - Stimulus: hold i_Btn[2] low for 40 clocks.
  - Required: exactly one o_fLong[2] pulse, 21 cycles after o_fPress[2]; no second pulse.
  - On release, o_fRelease[2] fires 7 cycles after i_Btn[2] returns high.
- Release bounce:
  - Stimulus: while pressed, i_Btn[0] goes high for 2 clocks then low again.
  - Required: o_Btn[0] stays 0; no o_fRelease[0]; no second o_fPress[0].
- Reset mid-press:
  - Stimulus: assert i_Rst = 0 for 1 clock while i_Btn[0] is held low and o_Btn[0] = 0.
  - Required: o_Btn[0] = 1 on the next edge.
  - After reset deasserts, o_fPress[0] fires again 7 cycles after the first post-reset edge.
